// File: rtl/asj_nco_sweep_ctrl.sv
// rtl/asj_nco_sweep_ctrl.sv - phase-increment sweep controller (single ramp, sawtooth, triangle) feeding the NCO
module asj_nco_sweep_ctrl #(
    parameter int apr = 20,
    parameter int dww = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clken,
    input  logic           cfg_load,
    input  logic [apr-1:0] start_i,
    input  logic [apr-1:0] stop_i,
    input  logic [apr-1:0] step_i,
    input  logic [dww-1:0] dwell_i,
    input  logic [1:0]     mode_i,
    input  logic           run,
    output logic [apr-1:0] phi_inc_o,
    output logic           busy,
    output logic           sweep_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [apr-1:0] r_start;
    logic [apr-1:0] r_stop;
    logic [apr-1:0] r_step;
    logic [dww-1:0] r_dwell;
    logic [1:0]     r_mode;
    logic [apr-1:0] r_phi;
    logic [apr-1:0] w_phi_nxt;
    logic [dww-1:0] r_cnt;
    logic [dww-1:0] w_cnt_nxt;
    logic           r_done;
    logic           w_done_nxt;

    // Extra top bit catches carry on the way up and borrow on the way down.
    logic [apr:0]   w_sum;
    logic [apr:0]   w_diff;
    logic           w_cfg_acc;
    logic           w_degen;

    assign w_sum     = {1'b0, r_phi} + {1'b0, r_step};
    assign w_diff    = {1'b0, r_phi} - {1'b0, r_step};
    assign w_cfg_acc = cfg_load && ((r_state == S_IDLE) || (r_state == S_HOLD));
    assign w_degen   = (r_start >= r_stop) || (r_step == '0);

    // Config capture: only while not sweeping, and regardless of clken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start <= '0;
            r_stop  <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_mode  <= '0;
        end else if (w_cfg_acc) begin
            r_start <= start_i;
            r_stop  <= stop_i;
            r_step  <= step_i;
            r_dwell <= dwell_i;
            r_mode  <= mode_i;
        end
    end

    // State register plus the registered increment, dwell count and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_phi   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phi   <= w_phi_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: everything holds unless clken; run=0 beats any dwell expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_phi_nxt   = r_phi;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        if (clken) begin
            if (!run) begin
                w_state_nxt = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // A config latched this cycle takes effect first; start on the next enable.
                        if (!w_cfg_acc) begin
                            w_phi_nxt = r_start;
                            if (w_degen) begin
                                w_state_nxt = S_HOLD;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = S_UP;
                                w_cnt_nxt   = r_dwell;
                            end
                        end
                    end
                    S_UP: begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - dww'(1);
                        end else begin
                            w_cnt_nxt = r_dwell;
                            if (w_sum >= {1'b0, r_stop}) begin
                                w_phi_nxt = r_stop;
                                case (r_mode)
                                    2'b01: w_phi_nxt = r_start;
                                    2'b10: w_state_nxt = S_DOWN;
                                    default: begin
                                        w_state_nxt = S_HOLD;
                                        w_done_nxt  = 1'b1;
                                    end
                                endcase
                            end else begin
                                w_phi_nxt = w_sum[apr-1:0];
                            end
                        end
                    end
                    S_DOWN: begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - dww'(1);
                        end else begin
                            w_cnt_nxt = r_dwell;
                            if (w_diff[apr] || (w_diff[apr-1:0] <= r_start)) begin
                                w_phi_nxt   = r_start;
                                w_state_nxt = S_UP;
                            end else begin
                                w_phi_nxt = w_diff[apr-1:0];
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = S_HOLD;
                    end
                endcase
            end
        end
    end

    // Outputs: busy follows the sweeping states, the rest come straight from registers.
    always_comb begin
        phi_inc_o  = r_phi;
        busy       = (r_state == S_UP) || (r_state == S_DOWN);
        sweep_done = r_done;
    end

endmodule

// File: tb/tb_asj_nco_sweep_ctrl.sv
// tb/tb_asj_nco_sweep_ctrl.sv - directed vector bench for asj_nco_sweep_ctrl
module tb_asj_nco_sweep_ctrl;

    localparam int APR = 20;
    localparam int DWW = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           clken = 1'b0;
    logic           cfg_load = 1'b0;
    logic [APR-1:0] start_i = '0;
    logic [APR-1:0] stop_i = '0;
    logic [APR-1:0] step_i = '0;
    logic [DWW-1:0] dwell_i = '0;
    logic [1:0]     mode_i = '0;
    logic           run = 1'b0;
    logic [APR-1:0] phi_inc_o;
    logic           busy;
    logic           sweep_done;

    asj_nco_sweep_ctrl #(.apr(APR), .dww(DWW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .cfg_load  (cfg_load),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .step_i    (step_i),
        .dwell_i   (dwell_i),
        .mode_i    (mode_i),
        .run       (run),
        .phi_inc_o (phi_inc_o),
        .busy      (busy),
        .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic           ce;
        logic           ld;
        logic           rn;
        logic [APR-1:0] start;
        logic [APR-1:0] stop;
        logic [APR-1:0] step;
        logic [DWW-1:0] dwell;
        logic [1:0]     mode;
        logic [APR-1:0] exp_phi;
        logic           exp_busy;
        logic           exp_done;
    } vec_t;

    vec_t           vecs[$];
    logic [APR-1:0] c_start, c_stop, c_step;
    logic [DWW-1:0] c_dwell;
    logic [1:0]     c_mode;
    int             n_tests = 0;
    int             n_fail = 0;

    task automatic cfg(input logic [APR-1:0] s, input logic [APR-1:0] p, input logic [APR-1:0] st,
                       input logic [DWW-1:0] d, input logic [1:0] m);
        c_start = s; c_stop = p; c_step = st; c_dwell = d; c_mode = m;
    endtask

    task automatic add(input logic rst, input logic ce, input logic ld, input logic rn,
                       input logic [APR-1:0] ephi, input logic eb, input logic ed);
        vec_t t;
        t.rst = rst; t.ce = ce; t.ld = ld; t.rn = rn;
        t.start = c_start; t.stop = c_stop; t.step = c_step; t.dwell = c_dwell; t.mode = c_mode;
        t.exp_phi = ephi; t.exp_busy = eb; t.exp_done = ed;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [APR-1:0] act, input logic [APR-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        cfg(0, 0, 0, 0, 0);
        // reset state
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        // single up, dwell 1
        cfg(100, 130, 10, 1, 0);
        add(0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 1, 100, 1, 0); add(0, 1, 0, 1, 100, 1, 0);
        add(0, 1, 0, 1, 110, 1, 0); add(0, 1, 0, 1, 110, 1, 0);
        add(0, 1, 0, 1, 120, 1, 0); add(0, 1, 0, 1, 120, 1, 0);
        add(0, 1, 0, 1, 130, 0, 1); add(0, 1, 0, 1, 130, 0, 0);
        add(0, 1, 0, 0, 130, 0, 0);
        // saturation at 25, with a cfg_load ignored while busy
        cfg(0, 25, 10, 0, 0);
        add(0, 1, 1, 0, 130, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0); add(0, 1, 0, 1, 10, 1, 0);
        cfg(500, 600, 1, 0, 0);
        add(0, 1, 1, 1, 20, 1, 0);
        add(0, 1, 0, 1, 25, 0, 1); add(0, 1, 0, 1, 25, 0, 0);
        add(0, 1, 0, 0, 25, 0, 0);
        // carry out of apr bits clamps to STOP
        cfg(20'hFFFF0, 20'hFFFFF, 20'h20, 0, 0);
        add(0, 1, 1, 0, 25, 0, 0);
        add(0, 1, 0, 1, 20'hFFFF0, 1, 0);
        add(0, 1, 0, 1, 20'hFFFFF, 0, 1); add(0, 1, 0, 1, 20'hFFFFF, 0, 0);
        add(0, 1, 0, 0, 20'hFFFFF, 0, 0);
        // triangle
        cfg(0, 30, 10, 0, 2);
        add(0, 1, 1, 0, 20'hFFFFF, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0);  add(0, 1, 0, 1, 10, 1, 0); add(0, 1, 0, 1, 20, 1, 0);
        add(0, 1, 0, 1, 30, 1, 0); add(0, 1, 0, 1, 20, 1, 0); add(0, 1, 0, 1, 10, 1, 0);
        add(0, 1, 0, 1, 0, 1, 0);  add(0, 1, 0, 1, 10, 1, 0); add(0, 1, 0, 1, 20, 1, 0);
        add(0, 1, 0, 0, 20, 0, 0);
        // clken stall: every value lasts twice as long, done pulse one clock only
        cfg(100, 130, 10, 1, 0);
        add(0, 1, 1, 0, 20, 0, 0);
        add(0, 1, 0, 1, 100, 1, 0); add(0, 0, 0, 1, 100, 1, 0);
        add(0, 1, 0, 1, 100, 1, 0); add(0, 0, 0, 1, 100, 1, 0);
        add(0, 1, 0, 1, 110, 1, 0); add(0, 0, 0, 1, 110, 1, 0);
        add(0, 1, 0, 1, 110, 1, 0); add(0, 0, 0, 1, 110, 1, 0);
        add(0, 1, 0, 1, 120, 1, 0); add(0, 0, 0, 1, 120, 1, 0);
        add(0, 1, 0, 1, 120, 1, 0); add(0, 0, 0, 1, 120, 1, 0);
        add(0, 1, 0, 1, 130, 0, 1); add(0, 0, 0, 1, 130, 0, 0);
        add(0, 1, 0, 0, 130, 0, 0);
        // STEP==0 degenerate start
        cfg(5, 10, 0, 0, 0);
        add(0, 1, 1, 0, 130, 0, 0);
        add(0, 1, 0, 1, 5, 0, 1); add(0, 1, 0, 1, 5, 0, 0);
        add(0, 1, 0, 0, 5, 0, 0);
        // cfg_load together with run in IDLE: start deferred one enable
        cfg(100, 130, 10, 1, 0);
        add(0, 1, 1, 1, 5, 0, 0);
        add(0, 1, 0, 1, 100, 1, 0); add(0, 1, 0, 1, 100, 1, 0);
        add(0, 1, 0, 1, 110, 1, 0); add(0, 1, 0, 1, 110, 1, 0);
        // run=0 on a dwell-expiry cycle: output holds, IDLE
        add(0, 1, 0, 0, 110, 0, 0);
        // new config accepted after abort
        cfg(0, 25, 10, 0, 0);
        add(0, 1, 1, 0, 110, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0); add(0, 1, 0, 1, 10, 1, 0);
        add(0, 1, 0, 0, 10, 0, 0);
        // reset at the 110 value, with clken low
        cfg(100, 130, 10, 1, 0);
        add(0, 1, 1, 0, 10, 0, 0);
        add(0, 1, 0, 1, 100, 1, 0); add(0, 1, 0, 1, 100, 1, 0); add(0, 1, 0, 1, 110, 1, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        // config cleared by reset: START>=STOP so the next run is degenerate
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; clken = vecs[i].ce; cfg_load = vecs[i].ld; run = vecs[i].rn;
            start_i = vecs[i].start; stop_i = vecs[i].stop; step_i = vecs[i].step;
            dwell_i = vecs[i].dwell; mode_i = vecs[i].mode;
            @(posedge clk);
            #1;
            check($sformatf("v%0d phi", i), phi_inc_o, vecs[i].exp_phi);
            check($sformatf("v%0d busy", i), APR'(busy), APR'(vecs[i].exp_busy));
            check($sformatf("v%0d done", i), APR'(sweep_done), APR'(vecs[i].exp_done));
        end

        // Long ramp in mode 11 (acts as single up): monotonic, bounded, ends at STOP with one done.
        begin
            logic [APR-1:0] prev;
            int viol;
            int dones;
            bit finished;
            viol = 0; dones = 0; finished = 0; prev = '0;
            @(negedge clk);
            reset = 1'b0; clken = 1'b1; run = 1'b0; cfg_load = 1'b1;
            start_i = 0; stop_i = 1000; step_i = 7; dwell_i = 2; mode_i = 2'b11;
            @(negedge clk);
            cfg_load = 1'b0; run = 1'b1;
            for (int k = 0; k < 2000 && !finished; k++) begin
                @(posedge clk);
                #1;
                if (phi_inc_o > 20'd1000 || phi_inc_o < prev) viol++;
                prev = phi_inc_o;
                if (sweep_done) begin
                    dones++;
                    finished = 1;
                end
            end
            check("ramp done seen", APR'(dones), APR'(1));
            check("ramp bound violations", APR'(viol), APR'(0));
            check("ramp final phi", phi_inc_o, 20'd1000);
            check("ramp busy after done", APR'(busy), APR'(0));
            @(posedge clk);
            #1;
            check("ramp done one cycle", APR'(sweep_done), APR'(0));
            check("ramp hold phi", phi_inc_o, 20'd1000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
